// File: rtl/mul_bus_slave_pkg.sv
// Shared definitions for the multiplier bus slave: FSM state encoding,
// register word addresses and CTRL/STATUS bit positions.
package mul_bus_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        ABORT = 2'b10
    } state_t;

    localparam logic [2:0] ADDR_OPA     = 3'd0;
    localparam logic [2:0] ADDR_OPB     = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_RES_LO  = 3'd4;
    localparam logic [2:0] ADDR_RES_HI  = 3'd5;
    localparam logic [2:0] ADDR_INT_EN  = 3'd6;
    localparam logic [2:0] ADDR_CYCLES  = 3'd7;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_CLEAR   = 1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_TIMEOUT = 2;

    localparam int unsigned INT_EN_BIT   = 0;

endpackage

// File: rtl/mul_bus_regfile.sv
// Register file for the multiplier bus slave: address decode for the
// software-owned registers (OPA, OPB, INT_EN) and the combinational read mux.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   s_sel/s_wr/s_addr/s_din/s_dout  slave bus
//   busy, done, timeout   status bits from the control FSM
//   res_lo, res_hi, cycles captured result and latency
//   opa, opb              operand registers
//   int_en, int_en_nxt    interrupt enable and its next-cycle value
module mul_bus_regfile
    import mul_bus_slave_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_sel,
    input  logic             s_wr,
    input  logic [2:0]       s_addr,
    input  logic [31:0]      s_din,
    output logic [31:0]      s_dout,
    input  logic             busy,
    input  logic             done,
    input  logic             timeout,
    input  logic [31:0]      res_lo,
    input  logic [31:0]      res_hi,
    input  logic [CNT_W-1:0] cycles,
    output logic [31:0]      opa,
    output logic [31:0]      opb,
    output logic             int_en,
    output logic             int_en_nxt
);

    logic wr_en;
    assign wr_en = s_sel & s_wr;

    // The interrupt output is registered from next-state values so that it
    // tracks an INT_EN write on the same edge.
    assign int_en_nxt = (wr_en && s_addr == ADDR_INT_EN) ? s_din[INT_EN_BIT] : int_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa    <= '0;
            opb    <= '0;
            int_en <= 1'b0;
        end else begin
            // Operands are frozen while the core is using them.
            if (wr_en && !busy && s_addr == ADDR_OPA) opa <= s_din;
            if (wr_en && !busy && s_addr == ADDR_OPB) opb <= s_din;
            int_en <= int_en_nxt;
        end
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (s_addr)
                ADDR_OPA:    s_dout = opa;
                ADDR_OPB:    s_dout = opb;
                ADDR_STATUS: begin
                    s_dout[STAT_BUSY]    = busy;
                    s_dout[STAT_DONE]    = done;
                    s_dout[STAT_TIMEOUT] = timeout;
                end
                ADDR_RES_LO: s_dout = res_lo;
                ADDR_RES_HI: s_dout = res_hi;
                ADDR_INT_EN: s_dout[INT_EN_BIT] = int_en;
                ADDR_CYCLES: s_dout = {{(32-CNT_W){1'b0}}, cycles};
                default:     s_dout = '0;
            endcase
        end
    end

endmodule

// File: rtl/mul_bus_slave.sv
// Bus-facing register front end for the 32x32 multiplier core. Software
// loads operands and issues start/clear through CTRL; this block drives the
// core, captures the 64-bit product and its latency, aborts a stuck
// operation after TIMEOUT_CYCLES and raises a level interrupt.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   s_sel/s_wr/s_addr/s_din/s_dout slave bus (s_dout combinational)
//   multiplier, multiplicand      operands to the core
//   op_start, op_clear            start level / one-cycle clear to the core
//   op_done, result               completion and product from the core
//   m_interrupt                   level interrupt
module mul_bus_slave
    import mul_bus_slave_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [2:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic [31:0] multiplier,
    output logic [31:0] multiplicand,
    output logic        op_start,
    output logic        op_clear,
    input  logic        op_done,
    input  logic [63:0] result,
    output logic        m_interrupt
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, cycles;
    logic [31:0]      res_lo, res_hi;
    logic             done, timeout, done_nxt, timeout_nxt;
    logic             clr_q;
    logic             int_en, int_en_nxt;
    logic             busy;
    logic             wr_en, ctrl_wr, stat_wr;
    logic             start_cmd, clear_cmd;
    logic             done_cap, hit_timeout;

    assign wr_en     = s_sel & s_wr;
    assign ctrl_wr   = wr_en && (s_addr == ADDR_CTRL);
    assign stat_wr   = wr_en && (s_addr == ADDR_STATUS);
    assign clear_cmd = ctrl_wr & s_din[CTRL_CLEAR];
    assign start_cmd = ctrl_wr & s_din[CTRL_START] & ~s_din[CTRL_CLEAR];

    assign busy        = (state != IDLE);
    assign cnt_inc     = cnt + 1'b1;
    assign done_cap    = (state == EXEC) && op_done;
    assign hit_timeout = (state == EXEC) && !op_done && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    assign op_start = (state == EXEC);
    assign op_clear = clr_q | (state == ABORT);

    mul_bus_regfile #(
        .CNT_W (CNT_W)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_sel      (s_sel),
        .s_wr       (s_wr),
        .s_addr     (s_addr),
        .s_din      (s_din),
        .s_dout     (s_dout),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .cycles     (cycles),
        .opa        (multiplier),
        .opb        (multiplicand),
        .int_en     (int_en),
        .int_en_nxt (int_en_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_cmd) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_cmd) state_nxt = EXEC;
                EXEC: begin
                    if (op_done)          state_nxt = IDLE;
                    else if (hit_timeout) state_nxt = ABORT;
                end
                ABORT:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status flag update order: W1C, then start-entry clear, then hardware
    // set (so a set beats a same-edge W1C), with CTRL clear overriding all.
    always_comb begin
        done_nxt    = done;
        timeout_nxt = timeout;
        if (stat_wr && s_din[STAT_DONE])    done_nxt    = 1'b0;
        if (stat_wr && s_din[STAT_TIMEOUT]) timeout_nxt = 1'b0;
        if (state == IDLE && start_cmd) begin
            done_nxt    = 1'b0;
            timeout_nxt = 1'b0;
        end
        if (done_cap)    done_nxt    = 1'b1;
        if (hit_timeout) timeout_nxt = 1'b1;
        if (clear_cmd) begin
            done_nxt    = 1'b0;
            timeout_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            cycles      <= '0;
            res_lo      <= '0;
            res_hi      <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            clr_q       <= 1'b0;
            m_interrupt <= 1'b0;
        end else begin
            cnt         <= (state == EXEC) ? cnt_inc : '0;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            m_interrupt <= int_en_nxt & (done_nxt | timeout_nxt);
            // A clear in ABORT already gets its pulse from the ABORT cycle.
            clr_q       <= clear_cmd && (state != ABORT);
            if (clear_cmd) begin
                res_lo <= '0;
                res_hi <= '0;
                cycles <= '0;
            end else if (done_cap) begin
                res_lo <= result[31:0];
                res_hi <= result[63:32];
                cycles <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mul_bus_slave.sv
module tb_mul_bus_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel, s_wr;
    logic [2:0]  s_addr;
    logic [31:0] s_din, s_dout;
    logic [31:0] multiplier, multiplicand;
    logic        op_start, op_clear, op_done, m_interrupt;
    logic [63:0] result;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mul_bus_slave #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_sel        (s_sel),
        .s_wr         (s_wr),
        .s_addr       (s_addr),
        .s_din        (s_din),
        .s_dout       (s_dout),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .op_done      (op_done),
        .result       (result),
        .m_interrupt  (m_interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at posedge+1.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk); #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1 v = s_dout;
        check(tag, {32'd0, v}, {32'd0, exp});
        @(posedge clk); #1;
        s_sel = 1'b0;
    endtask

    // Caller is in EXEC cycle 1; op_done is presented in EXEC cycle n.
    task automatic core_done_after(input int unsigned n, input logic [63:0] r);
        repeat (n - 1) @(posedge clk);
        #1;
        op_done = 1'b1; result = r;
        @(posedge clk); #1;
        op_done = 1'b0; result = '0;
    endtask

    initial begin
        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
        op_done = 1'b0; result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_start", {63'd0, op_start}, 64'd0);
        check("rst_op_clear", {63'd0, op_clear}, 64'd0);
        check("rst_irq", {63'd0, m_interrupt}, 64'd0);
        check("rst_mplier", {32'd0, multiplier}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) read_chk($sformatf("rst_read%0d", i), 3'(i), 32'd0);

        // 7 * 6 with 33-cycle latency
        bus_write(3'd0, 32'd7);
        bus_write(3'd1, 32'd6);
        bus_write(3'd6, 32'd1);
        read_chk("opa_rb", 3'd0, 32'd7);
        check("mcand", {32'd0, multiplicand}, 64'd6);
        bus_write(3'd2, 32'd1);
        check("start_lvl", {63'd0, op_start}, 64'd1);
        core_done_after(33, 64'd42);
        check("start_drop", {63'd0, op_start}, 64'd0);
        check("irq_done", {63'd0, m_interrupt}, 64'd1);
        read_chk("res_lo42", 3'd4, 32'd42);
        read_chk("res_hi42", 3'd5, 32'd0);
        read_chk("cycles33", 3'd7, 32'd33);
        read_chk("status_done", 3'd3, 32'd2);
        bus_write(3'd3, 32'd2);
        check("irq_w1c", {63'd0, m_interrupt}, 64'd0);
        read_chk("status_w1c", 3'd3, 32'd0);

        // max operands
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_write(3'd2, 32'd1);
        core_done_after(33, 64'hFFFF_FFFE_0000_0001);
        read_chk("res_lo_max", 3'd4, 32'h0000_0001);
        read_chk("res_hi_max", 3'd5, 32'hFFFF_FFFE);

        // op_done in IDLE must not capture
        op_done = 1'b1; result = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        op_done = 1'b0; result = '0;
        read_chk("idle_done_ign", 3'd4, 32'h0000_0001);

        // timeout: no op_done, abort after 64 EXEC cycles
        bus_write(3'd2, 32'd1);
        repeat (63) @(posedge clk);
        #1;
        check("to_pre_clear", {63'd0, op_clear}, 64'd0);
        check("to_pre_start", {63'd0, op_start}, 64'd1);
        @(posedge clk); #1;
        check("to_clear", {63'd0, op_clear}, 64'd1);
        check("to_start0", {63'd0, op_start}, 64'd0);
        @(posedge clk); #1;
        check("to_clear_end", {63'd0, op_clear}, 64'd0);
        read_chk("to_status", 3'd3, 32'd4);
        read_chk("to_res_hi", 3'd5, 32'hFFFF_FFFE);
        read_chk("to_cycles", 3'd7, 32'd33);
        check("to_irq", {63'd0, m_interrupt}, 64'd1);

        // writes while busy ignored, then clear with start also set
        bus_write(3'd2, 32'd1);
        bus_write(3'd0, 32'd5);
        check("busy_opa", {32'd0, multiplier}, 64'hFFFF_FFFF);
        bus_write(3'd2, 32'd1);
        check("busy_start", {63'd0, op_start}, 64'd1);
        bus_write(3'd2, 32'd3);
        check("clr_pulse", {63'd0, op_clear}, 64'd1);
        check("clr_start0", {63'd0, op_start}, 64'd0);
        @(posedge clk); #1;
        check("clr_pulse_end", {63'd0, op_clear}, 64'd0);
        check("clr_no_start", {63'd0, op_start}, 64'd0);
        read_chk("clr_res_lo", 3'd4, 32'd0);
        read_chk("clr_res_hi", 3'd5, 32'd0);
        read_chk("clr_cycles", 3'd7, 32'd0);
        read_chk("clr_status", 3'd3, 32'd0);
        read_chk("clr_opa_kept", 3'd0, 32'hFFFF_FFFF);

        // async reset mid-EXEC
        bus_write(3'd2, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_start", {63'd0, op_start}, 64'd0);
        check("arst_clear", {63'd0, op_clear}, 64'd0);
        check("arst_mplier", {32'd0, multiplier}, 64'd0);
        check("arst_irq", {63'd0, m_interrupt}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_write(3'd0, 32'd3);
        bus_write(3'd1, 32'd5);
        bus_write(3'd2, 32'd1);
        core_done_after(20, 64'd15);
        read_chk("post_rst_res", 3'd4, 32'd15);
        read_chk("post_rst_cyc", 3'd7, 32'd20);
        read_chk("post_rst_stat", 3'd3, 32'd2);
        check("post_rst_irq", {63'd0, m_interrupt}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_bus_slave.md
Name: mul_bus_slave

Overview:
- Bus-facing register front end for the 32x32 multiplier core. It sits directly upstream of the core.
- Software writes the operands and a start command. The block drives multiplier, multiplicand, op_start and op_clear, then waits for op_done.
- It captures the 64-bit result, measures the latency, and raises a level interrupt.
- It sits between the system bus and the multiplier core.

Parameters:
- TIMEOUT_CYCLES, 64, max EXEC cycles before the operation is aborted (core nominally needs 32-34).
- CNT_W, 7, width of the cycle counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_sel  in  1  slave select.
- s_wr  in  1  1=write, 0=read (valid when s_sel).
- s_addr  in  3  word address.
- s_din  in  32  write data.
- s_dout  out  32  read data; combinational; 0 when !s_sel or s_wr.
- multiplier  out  32  operand A to core (OPA register).
- multiplicand  out  32  operand B to core (OPB register).
- op_start  out  1  start level to core.
- op_clear  out  1  one-cycle clear pulse to core.
- op_done  in  1  core done.
- result  in  64  core product.
- m_interrupt  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk; reset_n asynchronous, active-low.
- Reset values:
  - All registers 0, state IDLE.
  - op_start=0, op_clear=0, m_interrupt=0, multiplier=0, multiplicand=0.
- Register map (s_addr):
  - 0 OPA RW.
  - 1 OPB RW.
  - 2 CTRL W: bit0 start, bit1 clear; reads 0.
  - 3 STATUS R/W1C: bit0 busy (RO), bit1 done (W1C), bit2 timeout (W1C).
  - 4 RES_LO RO.
  - 5 RES_HI RO.
  - 6 INT_EN RW bit0.
  - 7 CYCLES RO, zero-extended CNT_W.
- Writes take effect at the clk edge where s_sel&s_wr.
- Writes to OPA/OPB while busy are ignored.
- FSM states: IDLE, EXEC, ABORT.
  - IDLE: a CTRL write with bit0=1 and bit1=0 goes to EXEC next cycle. On entry: done=0, timeout=0, cnt=0, op_start=1.
  - EXEC: op_start held 1; cnt increments each cycle.
    - op_done=1: RES_LO/RES_HI <= result and CYCLES <= cnt+1 in that same edge; done=1; op_start=0; next state IDLE.
    - cnt+1 == TIMEOUT_CYCLES without op_done: timeout=1; next state ABORT.
  - ABORT: op_clear=1 for exactly one cycle, op_start=0, then IDLE. RES and CYCLES are unchanged.
- CTRL clear (bit1=1) in any state:
  - Next cycle: op_clear pulses 1 cycle, op_start=0, state=IDLE.
  - done, timeout, RES_LO/HI and CYCLES are zeroed. OPA/OPB are kept.
  - Clear has priority over start if both bits are set.
- Start while busy (EXEC/ABORT) is ignored.
- op_done arriving in IDLE is ignored.
- busy = (state != IDLE).
- m_interrupt = INT_EN[0] & (done | timeout), registered. It drops the cycle after the W1C write to STATUS.
- W1C conflict: a W1C of done on the same edge that sets done leaves done=1 (set wins).
- Reset mid-EXEC: immediate return to reset values. No op_clear is issued; the core shares reset_n.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, EXEC=2'b01, ABORT=2'b10), register address constants, STATUS/CTRL bit indices.
- One sub-module is natural: mul_bus_regfile (address decode, OPA/OPB/INT_EN storage, read mux). The FSM, counter and result capture stay in the top module.

Test Plan:
- Reset then read all addresses -> every read returns 0; m_interrupt=0, op_start=0.
- Write OPA=32'd7, OPB=32'd6, INT_EN=1, CTRL=1; core model asserts op_done after 33 cycles with result=64'd42 -> RES_LO=42, RES_HI=0, CYCLES=33, STATUS=3'b010, m_interrupt=1. Then W1C STATUS=2 -> m_interrupt=0 next cycle.
- OPA=32'hFFFFFFFF, OPB=32'hFFFFFFFF; core returns 64'hFFFFFFFE00000001 -> RES_HI=32'hFFFFFFFE, RES_LO=32'h00000001.
- Core never asserts op_done -> after 64 EXEC cycles timeout=1, a single op_clear pulse, busy=0; RES unchanged from the prior run.
- During EXEC: write OPA=5 and CTRL=1 -> both ignored (OPA readback is the old value). Then CTRL=2'b11 -> one op_clear pulse, IDLE, RES/CYCLES/done zeroed, no new start.
- Drop reset_n mid-EXEC for 1 cycle -> outputs 0 asynchronously; a later start runs normally.
